// File: rtl/contador_pkg.sv
// Shared types and helpers for the programmable counter block.
package contador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/contador_prog_if.sv
// Control/status bundle between a sequencer (master) and the counter (slave).
interface contador_prog_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             load_sel;
  logic [WIDTH-1:0] IN;
  logic             count;
  logic             up;
  logic [WIDTH-1:0] OUT;
  logic             zero;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_sel, IN, count, up,
    input  OUT, zero, tc, busy
  );

  modport slave (
    input  load, load_sel, IN, count, up,
    output OUT, zero, tc, busy
  );
endinterface

// File: rtl/contador_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each group.
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  // With PRESCALE=1, LAST is 0 so cnt_q is constant and tick reduces to en.
  always_ff @(posedge clk) begin
    if (clear || restart) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/contador_prog.sv
// Loadable up/down counter with prescaled enable, saturate/wrap mode and tc pulse.
//   state   | meaning
//   ST_IDLE | after clear, count ignored
//   ST_RUN  | counting on prescaler ticks
//   ST_DONE | saturated at terminal value, waits for load/clear
module contador_prog
  import contador_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int LOAD_DEFAULT = 4,
  parameter int PRESCALE     = 1,
  parameter int WRAP         = 0
) (
  input  logic           clk,
  input  logic           clear,
  contador_prog_if.slave bus
);
  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(LOAD_DEFAULT);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam bit               WRAP_EN  = (WRAP == MODE_WRAP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic [WIDTH-1:0] term, nxt;
  logic             tc_q, tc_d;
  logic             busy_q;
  logic             en, tick;

  assign en = (state_q == ST_RUN) && bus.count;

  contador_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk    (clk),
    .clear  (clear),
    .restart(bus.load),
    .en     (en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    term    = bus.up ? ALL_ONES : '0;
    nxt     = bus.up ? out_q + WIDTH'(1) : out_q - WIDTH'(1);

    if (bus.load) begin
      out_d   = bus.load_sel ? bus.IN : LOAD_VAL;
      rld_d   = bus.load_sel ? bus.IN : LOAD_VAL;
      state_d = ST_RUN;
    end else if (tick) begin
      if (out_q == term) begin
        // Already at terminal: wrap silently, or park in DONE without a tc.
        if (WRAP_EN) begin
          out_d = bus.up ? '0 : rld_q;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        out_d = nxt;
        if (nxt == term) begin
          tc_d = 1'b1;
          if (!WRAP_EN) state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == ST_RUN);
    end
  end

  assign bus.OUT  = out_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;
  assign bus.zero = (out_q == '0);

endmodule

// File: tb/tb_contador_prog.sv
// Scoreboard bench: three counter configurations driven by directed vectors.
module tb_contador_prog;

  logic clk = 1'b0;
  logic clear_a, clear_b, clear_c;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle = cycle + 1;

  contador_prog_if #(.WIDTH(4)) if_a ();
  contador_prog_if #(.WIDTH(4)) if_b ();
  contador_prog_if #(.WIDTH(4)) if_c ();

  // a: saturate, no prescale; b: saturate, prescale 3; c: wrap, no prescale
  contador_prog #(.WIDTH(4), .LOAD_DEFAULT(4), .PRESCALE(1), .WRAP(0)) u_a (
    .clk(clk), .clear(clear_a), .bus(if_a));
  contador_prog #(.WIDTH(4), .LOAD_DEFAULT(4), .PRESCALE(3), .WRAP(0)) u_b (
    .clk(clk), .clear(clear_b), .bus(if_b));
  contador_prog #(.WIDTH(4), .LOAD_DEFAULT(4), .PRESCALE(1), .WRAP(1)) u_c (
    .clk(clk), .clear(clear_c), .bus(if_c));

  typedef struct {
    int         id;
    int         cyc;
    logic [3:0] out;
    logic       tc;
    logic       busy;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input int id, input int cyc,
                     input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut=%0d cycle=%0d actual=%0d required=%0d", name, id, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      exp_t       e;
      logic [3:0] a_out;
      logic       a_tc, a_busy, a_zero;
      e = q.pop_front();
      case (e.id)
        0:       begin a_out = if_a.OUT; a_tc = if_a.tc; a_busy = if_a.busy; a_zero = if_a.zero; end
        1:       begin a_out = if_b.OUT; a_tc = if_b.tc; a_busy = if_b.busy; a_zero = if_b.zero; end
        default: begin a_out = if_c.OUT; a_tc = if_c.tc; a_busy = if_c.busy; a_zero = if_c.zero; end
      endcase
      chk("out",  e.id, e.cyc, a_out,         e.out);
      chk("tc",   e.id, e.cyc, {3'b0, a_tc},  {3'b0, e.tc});
      chk("busy", e.id, e.cyc, {3'b0, a_busy}, {3'b0, e.busy});
      chk("zero", e.id, e.cyc, {3'b0, a_zero}, {3'b0, (e.out == 4'd0)});
    end
  end

  task automatic drive(input int id, input int clr, input int ld, input int ls,
                       input int v, input int cnt, input int u);
    logic [3:0] v4;
    v4 = v[3:0];
    clear_a = 1'b0; if_a.load = 1'b0; if_a.load_sel = 1'b0; if_a.IN = 4'd0; if_a.count = 1'b0; if_a.up = 1'b0;
    clear_b = 1'b0; if_b.load = 1'b0; if_b.load_sel = 1'b0; if_b.IN = 4'd0; if_b.count = 1'b0; if_b.up = 1'b0;
    clear_c = 1'b0; if_c.load = 1'b0; if_c.load_sel = 1'b0; if_c.IN = 4'd0; if_c.count = 1'b0; if_c.up = 1'b0;
    case (id)
      0: begin clear_a = clr[0]; if_a.load = ld[0]; if_a.load_sel = ls[0]; if_a.IN = v4; if_a.count = cnt[0]; if_a.up = u[0]; end
      1: begin clear_b = clr[0]; if_b.load = ld[0]; if_b.load_sel = ls[0]; if_b.IN = v4; if_b.count = cnt[0]; if_b.up = u[0]; end
      default: begin clear_c = clr[0]; if_c.load = ld[0]; if_c.load_sel = ls[0]; if_c.IN = v4; if_c.count = cnt[0]; if_c.up = u[0]; end
    endcase
  endtask

  // One clock: apply inputs, queue the state expected after the coming edge.
  task automatic s(input int id, input int clr, input int ld, input int ls, input int v,
                   input int cnt, input int u, input int eout, input int etc, input int ebusy);
    exp_t e;
    drive(id, clr, ld, ls, v, cnt, u);
    e.id = id; e.cyc = cycle + 1; e.out = eout[3:0]; e.tc = etc[0]; e.busy = ebusy[0];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    //  id clr ld ls IN cnt up | OUT tc busy
    // Default load, count down to 0 and saturate
    s(0, 1, 0, 0, 0, 0, 0,   0, 0, 0);
    s(0, 0, 1, 0, 9, 1, 0,   4, 0, 1);
    s(0, 0, 0, 0, 0, 1, 0,   3, 0, 1);
    s(0, 0, 0, 0, 0, 1, 0,   2, 0, 1);
    s(0, 0, 0, 0, 0, 1, 0,   1, 0, 1);
    s(0, 0, 0, 0, 0, 1, 0,   0, 1, 0);
    s(0, 0, 0, 0, 0, 1, 0,   0, 0, 0);
    s(0, 0, 0, 0, 0, 1, 0,   0, 0, 0);
    // Up count saturating at 15, then loading the terminal value directly
    s(0, 0, 1, 1, 14, 0, 1, 14, 0, 1);
    s(0, 0, 0, 0, 0, 1, 1,  15, 1, 0);
    s(0, 0, 0, 0, 0, 1, 1,  15, 0, 0);
    s(0, 0, 0, 0, 0, 1, 1,  15, 0, 0);
    s(0, 0, 1, 1, 15, 1, 1, 15, 0, 1);
    s(0, 0, 0, 0, 0, 1, 1,  15, 0, 0);
    s(0, 0, 0, 0, 0, 1, 1,  15, 0, 0);
    // Same-cycle conflicts
    s(0, 0, 1, 1, 9, 0, 0,   9, 0, 1);
    s(0, 1, 1, 1, 7, 1, 0,   0, 0, 0);
    for (int i = 0; i < 5; i++) s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    s(0, 0, 1, 1, 3, 0, 0,   3, 0, 1);
    s(0, 0, 1, 1, 7, 1, 0,   7, 0, 1);
    s(0, 0, 0, 0, 0, 1, 0,   6, 0, 1);

    // Prescale 3 with a count gap mid-run
    s(1, 1, 0, 0, 0, 0, 0,   0, 0, 0);
    s(1, 0, 1, 1, 5, 1, 0,   5, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   5, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   5, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   4, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   4, 0, 1);
    s(1, 0, 0, 0, 0, 0, 0,   4, 0, 1);
    s(1, 0, 0, 0, 0, 0, 0,   4, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   4, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   3, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   3, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   3, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   2, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   2, 0, 1);
    // Clear with prescaler at 1 discards progress
    s(1, 1, 0, 0, 0, 1, 0,   0, 0, 0);
    s(1, 0, 1, 1, 5, 1, 0,   5, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   5, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   5, 0, 1);
    s(1, 0, 0, 0, 0, 1, 0,   4, 0, 1);

    // Wrap mode, down from 2 with reload, then reload 0, then up wrap
    s(2, 1, 0, 0, 0, 0, 0,   0, 0, 0);
    s(2, 0, 1, 1, 2, 1, 0,   2, 0, 1);
    s(2, 0, 0, 0, 0, 1, 0,   1, 0, 1);
    s(2, 0, 0, 0, 0, 1, 0,   0, 1, 1);
    s(2, 0, 0, 0, 0, 1, 0,   2, 0, 1);
    s(2, 0, 0, 0, 0, 1, 0,   1, 0, 1);
    s(2, 0, 0, 0, 0, 1, 0,   0, 1, 1);
    s(2, 0, 0, 0, 0, 1, 0,   2, 0, 1);
    s(2, 0, 1, 1, 0, 0, 0,   0, 0, 1);
    s(2, 0, 0, 0, 0, 1, 0,   0, 0, 1);
    s(2, 0, 0, 0, 0, 1, 0,   0, 0, 1);
    s(2, 0, 1, 1, 14, 0, 1, 14, 0, 1);
    s(2, 0, 0, 0, 0, 1, 1,  15, 1, 1);
    s(2, 0, 0, 0, 0, 1, 1,   0, 0, 1);
    s(2, 0, 0, 0, 0, 1, 1,   1, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
